// File: rtl/noc_packet_buffer.sv
// AXI-Stream circular packet buffer with store-and-forward or cut-through
// release, a completed-packet counter and a sticky oversize indication.
module noc_packet_buffer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int PKT_MODE = 1
) (
  input  logic                clk_in,
  input  logic                clk_in_rst_low,
  input  logic                stream_in_TVALID,
  input  logic [DATA_W-1:0]   stream_in_TDATA,
  input  logic [DATA_W/8-1:0] stream_in_TKEEP,
  input  logic                stream_in_TLAST,
  output logic                stream_in_TREADY,
  output logic                stream_out_TVALID,
  output logic [DATA_W-1:0]   stream_out_TDATA,
  output logic [DATA_W/8-1:0] stream_out_TKEEP,
  output logic                stream_out_TLAST,
  input  logic                stream_out_TREADY,
  output logic [ADDR_W:0]     level,
  output logic [ADDR_W:0]     pkt_count,
  output logic                oversize_flag
);

  localparam int KEEP_W      = DATA_W / 8;
  localparam int ENTRY_W     = DATA_W + KEEP_W + 1;
  localparam int NUM_ENTRIES = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE        = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  logic [1:0]         rst_sync;
  logic               run;
  logic [ENTRY_W-1:0] mem [NUM_ENTRIES];
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               rd_en;
  logic               in_last_acc;
  logic               out_last_acc;
  logic               force_rel;
  state_t             state_q;
  state_t             state_d;

  // Reset release passes two flops so TREADY rises on a clean edge, never racing the deassertion.
  always_ff @(posedge clk_in or negedge clk_in_rst_low) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!clk_in_rst_low) rst_sync <= 2'b00;
    else                 rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run              = rst_sync[1];
  assign level            = wr_ptr - rd_ptr;
  assign full             = (level == FULL_LEVEL);
  assign empty            = (level == '0);
  assign stream_in_TREADY = run & ~full;
  assign wr_en            = stream_in_TVALID & stream_in_TREADY;
  assign rd_en            = stream_out_TVALID & stream_out_TREADY;
  assign in_last_acc      = wr_en & stream_in_TLAST;
  assign out_last_acc     = rd_en & stream_out_TLAST;

  // Head entry is read combinationally: a word is visible the cycle after it is written.
  assign {stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA} = mem[rd_ptr[ADDR_W-1:0]];

  // NOTE: the storage array has no reset; only pointers define which entries are valid.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d           = state_q;
    stream_out_TVALID = 1'b0;
    force_rel         = 1'b0;
    if (PKT_MODE == 0) begin
      stream_out_TVALID = ~empty;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pkt_count != '0) begin
            state_d = ST_SEND;
          end else if (full) begin
            // A packet larger than the buffer can never complete; let it drain as cut-through.
            state_d   = ST_SEND;
            force_rel = 1'b1;
          end
        end
        ST_SEND: begin
          stream_out_TVALID = ~empty;
          if (~empty & stream_out_TREADY & stream_out_TLAST) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge clk_in_rst_low) begin
    if (!clk_in_rst_low) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pkt_count     <= '0;
      state_q       <= ST_IDLE;
      oversize_flag <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      unique case ({in_last_acc, out_last_acc})
        2'b10:   pkt_count <= pkt_count + ONE;
        2'b01:   pkt_count <= pkt_count - ONE;
        default: pkt_count <= pkt_count;
      endcase
      state_q <= state_d;
      if (force_rel) oversize_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_packet_buffer.sv
// Directed bench for noc_packet_buffer: a store-and-forward and a cut-through
// instance side by side, with a scoreboard on the store-and-forward stream.
module tb_noc_packet_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int KEEP_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + KEEP_W + 1;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  logic              sf_in_valid = 1'b0, sf_in_last = 1'b0, sf_in_ready;
  logic [DATA_W-1:0] sf_in_data  = '0;
  logic [KEEP_W-1:0] sf_in_keep  = '0;
  logic              sf_out_valid, sf_out_last, sf_out_ready = 1'b0;
  logic [DATA_W-1:0] sf_out_data;
  logic [KEEP_W-1:0] sf_out_keep;
  logic [ADDR_W:0]   sf_level, sf_pkt;
  logic              sf_over;

  logic              ct_in_valid = 1'b0, ct_in_last = 1'b0, ct_in_ready;
  logic [DATA_W-1:0] ct_in_data  = '0;
  logic [KEEP_W-1:0] ct_in_keep  = '0;
  logic              ct_out_valid, ct_out_last, ct_out_ready = 1'b0;
  logic [DATA_W-1:0] ct_out_data;
  logic [KEEP_W-1:0] ct_out_keep;
  logic [ADDR_W:0]   ct_level, ct_pkt;
  logic              ct_over;

  int n_vec = 0;
  int n_err = 0;
  int out_cnt = 0;
  bit rand_rdy = 1'b0;

  always #5 clk_in = ~clk_in;

  noc_packet_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PKT_MODE(1)) u_sf (
    .clk_in(clk_in), .clk_in_rst_low(rst_n),
    .stream_in_TVALID(sf_in_valid), .stream_in_TDATA(sf_in_data),
    .stream_in_TKEEP(sf_in_keep), .stream_in_TLAST(sf_in_last),
    .stream_in_TREADY(sf_in_ready),
    .stream_out_TVALID(sf_out_valid), .stream_out_TDATA(sf_out_data),
    .stream_out_TKEEP(sf_out_keep), .stream_out_TLAST(sf_out_last),
    .stream_out_TREADY(sf_out_ready),
    .level(sf_level), .pkt_count(sf_pkt), .oversize_flag(sf_over)
  );

  noc_packet_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PKT_MODE(0)) u_ct (
    .clk_in(clk_in), .clk_in_rst_low(rst_n),
    .stream_in_TVALID(ct_in_valid), .stream_in_TDATA(ct_in_data),
    .stream_in_TKEEP(ct_in_keep), .stream_in_TLAST(ct_in_last),
    .stream_in_TREADY(ct_in_ready),
    .stream_out_TVALID(ct_out_valid), .stream_out_TDATA(ct_out_data),
    .stream_out_TKEEP(ct_out_keep), .stream_out_TLAST(ct_out_last),
    .stream_out_TREADY(ct_out_ready),
    .level(ct_level), .pkt_count(ct_pkt), .oversize_flag(ct_over)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
    if (rand_rdy) sf_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  // Call only right after an input-change point; returns at the next one.
  task automatic send_word(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
    int  w = 0;
    logic acc = 1'b0;
    sf_in_valid = 1'b1;
    sf_in_data  = d;
    sf_in_keep  = k;
    sf_in_last  = l;
    do begin
      mid();
      acc = sf_in_ready;
      cyc();
      w++;
    end while (!acc && w < 500);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    sf_in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int w = 0;
    mid();
    while ((sf_level != '0 || sf_out_valid) && w < 1000) begin
      cyc();
      mid();
      w++;
    end
    check(tag, 64'(sf_level), 64'd0);
    cyc();
  endtask

  // Scoreboard on the store-and-forward stream plus the AXI hold rule.
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] held = '0;
  logic             stall_q = 1'b0;

  always @(negedge clk_in) begin
    logic [ENT_W-1:0] out_w;
    int               depth;
    out_w = {sf_out_last, sf_out_keep, sf_out_data};
    if (!rst_n) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 64'(sf_out_valid), 64'd1);
        check("hold_word", 64'(out_w), 64'(held));
      end
      if (sf_out_valid && sf_out_ready) begin
        depth = exp_q.size();
        if (depth == 0) check("sb_underflow", 64'(depth), 64'd1);
        else begin
          check("sb_word", 64'(out_w), 64'(exp_q.pop_front()));
          out_cnt++;
        end
      end
      if (sf_in_valid && sf_in_ready) exp_q.push_back({sf_in_last, sf_in_keep, sf_in_data});
      stall_q = sf_out_valid & ~sf_out_ready;
      held    = out_w;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int base;
    int sent;
    int len;

    // Reset state and synchronised release
    repeat (3) cyc();
    mid();
    check("rst_sf_ready", 64'(sf_in_ready), 64'd0);
    check("rst_ct_ready", 64'(ct_in_ready), 64'd0);
    check("rst_sf_valid", 64'(sf_out_valid), 64'd0);
    check("rst_sf_level", 64'(sf_level), 64'd0);
    check("rst_sf_pkt", 64'(sf_pkt), 64'd0);
    check("rst_sf_over", 64'(sf_over), 64'd0);
    cyc();
    rst_n = 1'b1;
    mid();
    check("rel_ready_e0", 64'(sf_in_ready), 64'd0);
    cyc();
    mid();
    check("rel_ready_e1", 64'(sf_in_ready), 64'd0);
    cyc();
    mid();
    check("rel_ready_e2", 64'(sf_in_ready), 64'd1);
    check("rel_ct_ready_e2", 64'(ct_in_ready), 64'd1);
    cyc();

    // Cut-through single word: visible the cycle after its write, then drains
    ct_in_valid = 1'b1; ct_in_data = 32'hA5A5_0001; ct_in_keep = 4'h3; ct_in_last = 1'b1;
    mid();
    check("ct_no_bypass", 64'(ct_out_valid), 64'd0);
    cyc();
    ct_in_valid = 1'b0;
    ct_out_ready = 1'b1;
    mid();
    check("ct_valid", 64'(ct_out_valid), 64'd1);
    check("ct_data", 64'(ct_out_data), 64'h0000_0000_A5A5_0001);
    check("ct_keep", 64'(ct_out_keep), 64'h3);
    check("ct_level1", 64'(ct_level), 64'd1);
    cyc();
    ct_out_ready = 1'b0;
    mid();
    check("ct_level0", 64'(ct_level), 64'd0);
    check("ct_valid0", 64'(ct_out_valid), 64'd0);
    cyc();

    // Store-and-forward 3-word packet
    sf_out_ready = 1'b1;
    send_word(32'hA1, 4'hF, 1'b0);
    mid();
    check("sf_hold_a1", 64'(sf_out_valid), 64'd0);
    check("sf_level_a1", 64'(sf_level), 64'd1);
    cyc();
    send_word(32'hA2, 4'hF, 1'b0);
    mid();
    check("sf_hold_a2", 64'(sf_out_valid), 64'd0);
    cyc();
    send_word(32'hA3, 4'hF, 1'b1);
    mid();
    check("sf_pkt_a3", 64'(sf_pkt), 64'd1);
    check("sf_level_a3", 64'(sf_level), 64'd3);
    k = 0;
    while (!sf_out_valid && k < 4) begin
      cyc();
      mid();
      k++;
    end
    check("sf_release", 64'(sf_out_valid), 64'd1);
    check("sf_out_a1", 64'(sf_out_data), 64'hA1);
    check("sf_last_a1", 64'(sf_out_last), 64'd0);
    cyc();
    mid();
    check("sf_out_a2", 64'(sf_out_data), 64'hA2);
    check("sf_valid_a2", 64'(sf_out_valid), 64'd1);
    cyc();
    mid();
    check("sf_out_a3", 64'(sf_out_data), 64'hA3);
    check("sf_last_a3", 64'(sf_out_last), 64'd1);
    check("sf_pkt_before", 64'(sf_pkt), 64'd1);
    cyc();
    mid();
    check("sf_pkt_after", 64'(sf_pkt), 64'd0);
    check("sf_valid_end", 64'(sf_out_valid), 64'd0);
    cyc();

    // Cut-through full buffer: a read while full does not admit a write
    ct_in_valid = 1'b1; ct_in_keep = 4'hF; ct_in_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ct_in_data = 32'(100 + i);
      cyc();
    end
    ct_in_data = 32'hEE;
    ct_out_ready = 1'b1;
    mid();
    check("full_ready", 64'(ct_in_ready), 64'd0);
    check("full_level", 64'(ct_level), 64'd16);
    check("full_head", 64'(ct_out_data), 64'd100);
    cyc();
    ct_out_ready = 1'b0;
    mid();
    check("full_rd_level", 64'(ct_level), 64'd15);
    check("full_rd_ready", 64'(ct_in_ready), 64'd1);
    cyc();
    ct_in_valid = 1'b0;
    mid();
    check("full_wr_level", 64'(ct_level), 64'd16);
    cyc();
    ct_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mid();
      check("full_drain", 64'(ct_out_data), (i < 15) ? 64'(101 + i) : 64'hEE);
      cyc();
    end
    ct_out_ready = 1'b0;
    mid();
    check("full_drained", 64'(ct_level), 64'd0);
    cyc();

    // Oversize packet: forced release, 20 words in order
    base = out_cnt;
    for (int i = 0; i < 20; i++) send_word(32'(200 + i), 4'hF, i == 19);
    mid();
    check("over_flag", 64'(sf_over), 64'd1);
    cyc();
    wait_empty("over_drain");
    mid();
    check("over_count", 64'(out_cnt - base), 64'd20);
    check("over_pkt", 64'(sf_pkt), 64'd0);
    check("over_sticky", 64'(sf_over), 64'd1);
    cyc();

    // Input TLAST and output TLAST accepted together at pkt_count 2
    sf_out_ready = 1'b0;
    send_word(32'hB1, 4'h1, 1'b1);
    send_word(32'hB2, 4'h3, 1'b1);
    mid();
    check("simul_pkt2", 64'(sf_pkt), 64'd2);
    k = 0;
    while (!sf_out_valid && k < 4) begin
      cyc();
      mid();
      k++;
    end
    check("simul_head", 64'(sf_out_data), 64'hB1);
    cyc();
    sf_in_valid = 1'b1; sf_in_data = 32'hB3; sf_in_keep = 4'h7; sf_in_last = 1'b1;
    sf_out_ready = 1'b1;
    mid();
    check("simul_in_ready", 64'(sf_in_ready), 64'd1);
    check("simul_out_last", 64'(sf_out_last), 64'd1);
    cyc();
    sf_in_valid = 1'b0;
    sf_out_ready = 1'b0;
    mid();
    check("simul_pkt_hold", 64'(sf_pkt), 64'd2);
    check("simul_level", 64'(sf_level), 64'd2);
    cyc();
    sf_out_ready = 1'b1;
    wait_empty("simul_drain");

    // 40 random packets with random downstream stalls, across pointer wrap
    base = out_cnt;
    sent = 0;
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++) begin
        send_word($urandom, 4'($urandom_range(1, 15)), w == len - 1);
        sent++;
      end
    end
    wait_empty("rand_drain");
    rand_rdy = 1'b0;
    sf_out_ready = 1'b0;
    mid();
    check("rand_count", 64'(out_cnt - base), 64'(sent));
    check("rand_pkt", 64'(sf_pkt), 64'd0);
    cyc();

    // Reset mid-packet with five words stored
    send_word(32'hC1, 4'hF, 1'b0);
    send_word(32'hC2, 4'hF, 1'b0);
    send_word(32'hC3, 4'hF, 1'b1);
    send_word(32'hD1, 4'hF, 1'b0);
    send_word(32'hD2, 4'hF, 1'b0);
    mid();
    k = 0;
    while (!sf_out_valid && k < 4) begin
      cyc();
      mid();
      k++;
    end
    check("mid_level5", 64'(sf_level), 64'd5);
    check("mid_valid", 64'(sf_out_valid), 64'd1);
    check("mid_over_pre", 64'(sf_over), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(sf_out_valid), 64'd0);
    check("mid_rst_level", 64'(sf_level), 64'd0);
    check("mid_rst_pkt", 64'(sf_pkt), 64'd0);
    check("mid_rst_over", 64'(sf_over), 64'd0);
    check("mid_rst_ready", 64'(sf_in_ready), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    mid();
    check("post_rst_ready", 64'(sf_in_ready), 64'd1);
    check("post_rst_level", 64'(sf_level), 64'd0);
    cyc();
    sf_out_ready = 1'b1;
    base = out_cnt;
    send_word(32'hE1, 4'hF, 1'b0);
    send_word(32'hE2, 4'h3, 1'b1);
    wait_empty("post_rst_drain");
    mid();
    check("post_rst_count", 64'(out_cnt - base), 64'd2);
    check("post_rst_pkt", 64'(sf_pkt), 64'd0);
    check("post_rst_over", 64'(sf_over), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
